// File: rtl/rv32i_types.sv
// Shared types for the ALU issue path.
//   rs_t   : one reservation-station entry as seen by the issue unit
//   sal_t  : per-slot completion record {rdy, tag, data} driven back to the RS
//   alu_ops / cmp_ops : operation encodings for the integer ALU and comparator
package rv32i_types;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = 4;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  // slt/sltu are issued as blt/bltu.
  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } cmp_ops;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      r1;
    logic [31:0]      r2;
    alu_ops           alu_opcode;
    cmp_ops           cmp_opcode;
    logic             is_cmp;
  } rs_t;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } sal_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i         : request vector, one bit per slot
//   ptr_i         : highest-priority slot this cycle; search runs upward and wraps
//   grant_idx_o   : first requesting slot at or after ptr_i
//   grant_valid_o : any request present
module rr_arbiter #(
  parameter  int SIZE  = 8,
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back toward ptr_i so the nearest request wins.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % SIZE);
      if (req_i[cand]) begin
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: picks one ready RS entry per cycle, runs it through a
// single-cycle ALU/comparator (EX stage) and holds the result in WB until the
// CDB accepts it. The acceptance cycle also pulses done_bus for that slot.
//   clk, rst (async, active-low), flush (sync mispredict clear)
//   rs_data/rs_ready : RS entries and their ready flags
//   cdb_ack          : CDB takes the WB result this cycle
//   cdb_valid/tag/data : WB result (registered)
//   done_bus         : per-slot completion pulse, coincident with cdb_ack
//   busy             : EX or WB occupied
module alu_issue_unit
  import rv32i_types::*;
#(
  parameter int SIZE = RS_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  rs_t               rs_data [SIZE],
  input  logic [SIZE-1:0]   rs_ready,
  input  logic              cdb_ack,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [31:0]       cdb_data,
  output sal_t              done_bus [SIZE],
  output logic              busy
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0]  inflight_q, inflight_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  rs_t              ex_ent_q, ex_ent_d;   // ex_ent_q.valid is the EX occupancy flag
  logic [IDX_W-1:0] ex_idx_q, ex_idx_d;
  logic             wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic [SIZE-1:0]  entry_valid, eligible;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             wb_free, ex_free, issue, retire;
  logic [31:0]      alu_res, ex_result;
  logic             cmp_res;
  logic [4:0]       shamt;

  always_comb begin
    for (int i = 0; i < SIZE; i++) entry_valid[i] = rs_data[i].valid;
  end

  // A slot already in EX/WB stays masked until its done pulse.
  assign eligible = rs_ready & entry_valid & ~inflight_q;

  rr_arbiter #(.SIZE(SIZE)) u_arb (
    .req_i         (eligible),
    .ptr_i         (rr_ptr_q),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign wb_free = ~wb_valid_q | cdb_ack;
  assign ex_free = ~ex_ent_q.valid | wb_free;
  assign issue   = grant_valid & ex_free & ~flush;
  assign retire  = wb_valid_q & cdb_ack & ~flush;

  assign shamt = ex_ent_q.r2[4:0];

  always_comb begin
    alu_res = '0;
    cmp_res = 1'b0;
    case (ex_ent_q.alu_opcode)
      alu_add: alu_res = ex_ent_q.r1 + ex_ent_q.r2;
      alu_sub: alu_res = ex_ent_q.r1 - ex_ent_q.r2;
      alu_sll: alu_res = ex_ent_q.r1 << shamt;
      alu_srl: alu_res = ex_ent_q.r1 >> shamt;
      alu_sra: alu_res = unsigned'($signed(ex_ent_q.r1) >>> shamt);
      alu_xor: alu_res = ex_ent_q.r1 ^ ex_ent_q.r2;
      alu_or:  alu_res = ex_ent_q.r1 | ex_ent_q.r2;
      alu_and: alu_res = ex_ent_q.r1 & ex_ent_q.r2;
      default: alu_res = '0;
    endcase
    case (ex_ent_q.cmp_opcode)
      beq:     cmp_res = (ex_ent_q.r1 == ex_ent_q.r2);
      bne:     cmp_res = (ex_ent_q.r1 != ex_ent_q.r2);
      blt:     cmp_res = ($signed(ex_ent_q.r1) <  $signed(ex_ent_q.r2));
      bge:     cmp_res = ($signed(ex_ent_q.r1) >= $signed(ex_ent_q.r2));
      bltu:    cmp_res = (ex_ent_q.r1 <  ex_ent_q.r2);
      bgeu:    cmp_res = (ex_ent_q.r1 >= ex_ent_q.r2);
      default: cmp_res = 1'b0;
    endcase
  end

  assign ex_result = ex_ent_q.is_cmp ? {31'b0, cmp_res} : alu_res;

  always_comb begin
    ex_ent_d   = ex_ent_q;
    ex_idx_d   = ex_idx_q;
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_tag_d   = wb_tag_q;
    wb_data_d  = wb_data_q;
    inflight_d = inflight_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      ex_ent_d.valid = 1'b0;
      wb_valid_d     = 1'b0;
      inflight_d     = '0;
    end else begin
      if (wb_free) begin
        wb_valid_d = ex_ent_q.valid;
        if (ex_ent_q.valid) begin
          wb_idx_d  = ex_idx_q;
          wb_tag_d  = ex_ent_q.tag;
          wb_data_d = ex_result;
        end
      end
      if (issue) begin
        ex_ent_d = rs_data[grant_idx];
        ex_idx_d = grant_idx;
        rr_ptr_d = (grant_idx == IDX_W'(SIZE - 1)) ? '0 : grant_idx + 1'b1;
      end else if (wb_free) begin
        ex_ent_d.valid = 1'b0;
      end
      // Retiring and issuing slots are always different: issue requires ~inflight.
      if (retire) inflight_d[wb_idx_q]  = 1'b0;
      if (issue)  inflight_d[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      rr_ptr_q   <= '0;
      ex_ent_q   <= '0;
      ex_idx_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
      ex_ent_q   <= ex_ent_d;
      ex_idx_q   <= ex_idx_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Done pulse is combinational on cdb_ack so the RS frees the slot in the retire cycle.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      done_bus[i] = '0;
      if (retire && (wb_idx_q == IDX_W'(i))) begin
        done_bus[i].rdy  = 1'b1;
        done_bus[i].tag  = wb_tag_q;
        done_bus[i].data = wb_data_q;
      end
    end
  end

  assign cdb_valid = wb_valid_q;
  assign cdb_tag   = wb_tag_q;
  assign cdb_data  = wb_data_q;
  assign busy      = ex_ent_q.valid | wb_valid_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  import rv32i_types::*;

  localparam int N = RS_SIZE;

  logic             clk;
  logic             rst;
  logic             flush;
  rs_t              rs_data [N];
  logic [N-1:0]     rs_ready;
  logic             cdb_ack;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  sal_t             done_bus [N];
  logic             busy;

  int tests  = 0;
  int failed = 0;

  alu_issue_unit #(.SIZE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .rs_data   (rs_data),
    .rs_ready  (rs_ready),
    .cdb_ack   (cdb_ack),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .done_bus  (done_bus),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_ops      aop;
    cmp_ops      cop;
    logic        is_cmp;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int rdy_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (done_bus[i].rdy) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [TAG_W-1:0] tag, input alu_ops aop,
                          input cmp_ops cop, input logic is_cmp,
                          input logic [31:0] r1, input logic [31:0] r2);
    rs_data[s].valid      = 1'b1;
    rs_data[s].tag        = tag;
    rs_data[s].alu_opcode = aop;
    rs_data[s].cmp_opcode = cop;
    rs_data[s].is_cmp     = is_cmp;
    rs_data[s].r1         = r1;
    rs_data[s].r2         = r2;
  endtask

  task automatic do_reset();
    rs_ready = '0;
    cdb_ack  = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{alu_add, beq,  1'b0, 32'd5,        32'd7,        32'd12};
    vecs[1]  = '{alu_sub, beq,  1'b0, 32'd3,        32'd5,        32'hFFFF_FFFE};
    vecs[2]  = '{alu_sra, beq,  1'b0, 32'h8000_0000, 32'd4,       32'hF800_0000};
    vecs[3]  = '{alu_srl, beq,  1'b0, 32'h8000_0000, 32'd4,       32'h0800_0000};
    vecs[4]  = '{alu_sll, beq,  1'b0, 32'd1,        32'h0000_003F, 32'h8000_0000};
    vecs[5]  = '{alu_xor, beq,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[6]  = '{alu_or,  beq,  1'b0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF};
    vecs[7]  = '{alu_and, beq,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[8]  = '{alu_add, bltu, 1'b1, 32'd1,        32'hFFFF_FFFF, 32'd1};
    vecs[9]  = '{alu_add, blt,  1'b1, 32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[10] = '{alu_add, beq,  1'b1, 32'd5,        32'd5,        32'd1};
    vecs[11] = '{alu_add, bne,  1'b1, 32'd5,        32'd5,        32'd0};
    vecs[12] = '{alu_add, bge,  1'b1, 32'hFFFF_FFFF, 32'd1,       32'd0};
    vecs[13] = '{alu_add, bgeu, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd1};
    vecs[14] = '{alu_add, beq,  1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0};

    for (int i = 0; i < N; i++) rs_data[i] = '0;
    rst = 1'b0;
    flush = 1'b0;
    rs_ready = '0;
    cdb_ack = 1'b0;
    #3;
    chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("reset_cdb_tag",   32'(cdb_tag),   32'd0);
    chk("reset_cdb_data",  cdb_data,       32'd0);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(rdy_count()), 32'd0);
    do_reset();

    // Single-op table: slot (i+2)%8, tag (i+3)%16; vector 0 is slot 2 add 5+7 tag 3.
    for (int i = 0; i < 15; i++) begin
      int s;
      logic [TAG_W-1:0] tg;
      s  = (i + 2) % N;
      tg = TAG_W'((i + 3) % 16);
      set_slot(s, tg, vecs[i].aop, vecs[i].cop, vecs[i].is_cmp, vecs[i].r1, vecs[i].r2);
      rs_ready = N'(1) << s;
      cdb_ack  = 1'b1;
      tick();
      chk($sformatf("v%0d_ex_cdb_valid", i), 32'(cdb_valid), 32'd0);
      chk($sformatf("v%0d_ex_busy", i), 32'(busy), 32'd1);
      tick();
      chk($sformatf("v%0d_cdb_valid", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("v%0d_cdb_tag", i), 32'(cdb_tag), 32'(tg));
      chk($sformatf("v%0d_cdb_data", i), cdb_data, vecs[i].exp);
      chk($sformatf("v%0d_done_rdy", i), 32'(done_bus[s].rdy), 32'd1);
      chk($sformatf("v%0d_done_data", i), done_bus[s].data, vecs[i].exp);
      chk($sformatf("v%0d_done_cnt", i), 32'(rdy_count()), 32'd1);
      rs_ready = '0;
      tick();
      chk($sformatf("v%0d_after_valid", i), 32'(cdb_valid), 32'd0);
      chk($sformatf("v%0d_no_reissue", i), 32'(busy), 32'd0);
    end

    // All slots ready: issue order 0..7 then 0 again, one result per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_slot(i, TAG_W'(i), alu_add, beq, 1'b0, 32'(i), 32'd16);
    rs_ready = '1;
    cdb_ack  = 1'b1;
    tick();
    chk("rr_fill_valid", 32'(cdb_valid), 32'd0);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("rr%0d_valid", k), 32'(cdb_valid), 32'd1);
      chk($sformatf("rr%0d_tag", k), 32'(cdb_tag), 32'(k % N));
      chk($sformatf("rr%0d_data", k), cdb_data, 32'((k % N) + 16));
      chk($sformatf("rr%0d_done", k), 32'(done_bus[k % N].rdy), 32'd1);
    end
    rs_ready = '0;
    tick();
    tick();
    chk("rr_drain_busy", 32'(busy), 32'd0);

    // Backpressure: three ready, CDB stalled for five cycles.
    do_reset();
    set_slot(0, 4'd10, alu_add, beq, 1'b0, 32'd100, 32'd0);
    set_slot(1, 4'd11, alu_add, beq, 1'b0, 32'd200, 32'd0);
    set_slot(2, 4'd12, alu_add, beq, 1'b0, 32'd300, 32'd0);
    rs_ready = 8'h07;
    cdb_ack  = 1'b0;
    tick();
    tick();
    chk("bp_valid", 32'(cdb_valid), 32'd1);
    chk("bp_tag", 32'(cdb_tag), 32'd10);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d_data", c), cdb_data, 32'd100);
      chk($sformatf("bp%0d_tag", c), 32'(cdb_tag), 32'd10);
      chk($sformatf("bp%0d_no_done", c), 32'(rdy_count()), 32'd0);
    end
    cdb_ack  = 1'b1;
    rs_ready = 8'h04;
    #1;
    chk("bp_ack_done0", 32'(done_bus[0].rdy), 32'd1);
    chk("bp_ack_done0_data", done_bus[0].data, 32'd100);
    tick();
    chk("bp_drain1_tag", 32'(cdb_tag), 32'd11);
    chk("bp_drain1_data", cdb_data, 32'd200);
    chk("bp_drain1_done", 32'(done_bus[1].rdy), 32'd1);
    rs_ready = '0;
    tick();
    chk("bp_drain2_tag", 32'(cdb_tag), 32'd12);
    chk("bp_drain2_data", cdb_data, 32'd300);
    tick();
    chk("bp_drain_empty", 32'(cdb_valid), 32'd0);

    // Flush with EX and WB full and ack asserted: flush wins.
    do_reset();
    set_slot(3, 4'd3, alu_add, beq, 1'b0, 32'd33, 32'd0);
    set_slot(4, 4'd4, alu_add, beq, 1'b0, 32'd44, 32'd0);
    rs_ready = 8'h18;
    cdb_ack  = 1'b0;
    tick();
    tick();
    chk("fl_pre_valid", 32'(cdb_valid), 32'd1);
    flush   = 1'b1;
    cdb_ack = 1'b1;
    #1;
    chk("fl_no_done", 32'(rdy_count()), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    tick();
    chk("fl_reissue_ex", 32'(busy), 32'd1);
    chk("fl_reissue_ex_valid", 32'(cdb_valid), 32'd0);
    tick();
    chk("fl_reissue_valid", 32'(cdb_valid), 32'd1);
    chk("fl_reissue_tag", 32'(cdb_tag), 32'd3);
    chk("fl_reissue_data", cdb_data, 32'd33);
    rs_ready = '0;
    tick();
    tick();

    // Asynchronous reset mid-stream; rr_ptr restarts at 0.
    do_reset();
    set_slot(5, 4'd5, alu_add, beq, 1'b0, 32'h55, 32'd0);
    rs_ready = 8'h20;
    cdb_ack  = 1'b0;
    tick();
    tick();
    chk("ar_pre_data", cdb_data, 32'h55);
    #3;
    rst = 1'b0;
    #2;
    chk("ar_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("ar_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("ar_cdb_data", cdb_data, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    rs_ready = '0;
    @(negedge clk);
    rst = 1'b1;
    set_slot(3, 4'd3, alu_add, beq, 1'b0, 32'd30, 32'd0);
    set_slot(6, 4'd6, alu_add, beq, 1'b0, 32'd60, 32'd0);
    rs_ready = 8'h48;
    cdb_ack  = 1'b1;
    tick();
    tick();
    chk("ar_ptr_tag", 32'(cdb_tag), 32'd3);
    chk("ar_ptr_data", cdb_data, 32'd30);
    tick();
    chk("ar_second_tag", 32'(cdb_tag), 32'd6);
    rs_ready = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
